// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: folds E0/F0 prefixes into 10-bit key events
// ({extended, break, code}) and queues them in a small first-word-fall-through FIFO.
//
// state    | meaning
// IDLE     | between sequences, next byte starts a new one
// GOT_E0   | extended prefix seen, waiting for F0 or the code
// GOT_F0   | break prefix seen, waiting for the code
// GOT_E0F0 | extended break prefix seen, waiting for the code
module ps2_scancode_decoder #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       iReset,
    input  logic [7:0] i8b,
    input  logic       iValid,
    input  logic       iParityErr,
    input  logic       iRead,
    output logic [7:0] oCode,
    output logic       oBreak,
    output logic       oExtended,
    output logic       oEmpty,
    output logic       oFull,
    output logic       oError,
    output logic       oOverflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;
    localparam logic [7:0] B_AA = 8'hAA;
    localparam logic [7:0] B_00 = 8'h00;
    localparam logic [7:0] B_FF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_req;
    logic [9:0]    push_data;
    logic          seq_err;

    always_ff @(posedge Clock or negedge iReset) begin
        if (!iReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        push_req  = 1'b0;
        push_data = '0;
        seq_err   = 1'b0;
        if (iValid) begin
            cnt_d = '0;
            if (iParityErr) begin
                state_d = IDLE;
                seq_err = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i8b == B_E0) begin
                            state_d = GOT_E0;
                        end else if (i8b == B_F0) begin
                            state_d = GOT_F0;
                        end else if (i8b == B_AA) begin
                            state_d = IDLE;
                        end else if (i8b == B_00 || i8b == B_FF) begin
                            seq_err = 1'b1;
                        end else begin
                            push_req  = 1'b1;
                            push_data = {2'b00, i8b};
                        end
                    end
                    GOT_E0: begin
                        if (i8b == B_E0) begin
                            state_d = GOT_E0;
                        end else if (i8b == B_F0) begin
                            state_d = GOT_E0F0;
                        end else begin
                            state_d   = IDLE;
                            push_req  = 1'b1;
                            push_data = {2'b10, i8b};
                        end
                    end
                    GOT_F0: begin
                        if (i8b == B_F0) begin
                            state_d = GOT_F0;
                        end else if (i8b == B_E0) begin
                            state_d = IDLE;
                            seq_err = 1'b1;
                        end else begin
                            state_d   = IDLE;
                            push_req  = 1'b1;
                            push_data = {2'b01, i8b};
                        end
                    end
                    GOT_E0F0: begin
                        state_d = IDLE;
                        if (i8b == B_E0 || i8b == B_F0) begin
                            seq_err = 1'b1;
                        end else begin
                            push_req  = 1'b1;
                            push_data = {2'b11, i8b};
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q != IDLE) begin
            // Stalled mid-sequence: abandon it once the budget is spent.
            if (cnt_q == TO_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                seq_err = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [9:0]  mem_q [DEPTH];
    logic [9:0]  hold_q, hold_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic        fifo_empty, fifo_full, do_pop, do_push, drop;
    logic [9:0]  head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_comb begin
        do_pop   = iRead & ~fifo_empty;
        do_push  = push_req & (~fifo_full | do_pop);
        drop     = push_req & fifo_full & ~do_pop;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        // Remember the popped head so the outputs hold it once the FIFO drains.
        hold_d   = do_pop ? mem_q[rd_ptr_q[AW-1:0]] : hold_q;
        ovf_d    = ovf_q | drop;
        err_d    = seq_err | drop;
    end

    always_ff @(posedge Clock or negedge iReset) begin
        if (!iReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign head      = fifo_empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];
    assign oExtended = head[9];
    assign oBreak    = head[8];
    assign oCode     = head[7:0];
    assign oEmpty    = fifo_empty;
    assign oFull     = fifo_full;
    assign oError    = err_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected key events are queued as
// bytes are driven and compared against the FIFO head as it is read.
module tb_ps2_scancode_decoder;

    localparam int T = 20;
    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] i8b;
    logic       ivalid;
    logic       iperr;
    logic       iread;
    logic [7:0] ocode;
    logic       obreak;
    logic       oext;
    logic       oempty;
    logic       ofull;
    logic       oerror;
    logic       oovf;

    int n_checks = 0;
    int n_errs   = 0;
    int err_cnt  = 0;
    int err_base = 0;
    logic [9:0] exp_q[$];

    ps2_scancode_decoder #(.DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
        .Clock      (clk),
        .iReset     (rst_n),
        .i8b        (i8b),
        .iValid     (ivalid),
        .iParityErr (iperr),
        .iRead      (iread),
        .oCode      (ocode),
        .oBreak     (obreak),
        .oExtended  (oext),
        .oEmpty     (oempty),
        .oFull      (ofull),
        .oError     (oerror),
        .oOverflow  (oovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles with oError high; sampled before the edge updates it.
    always @(posedge clk) begin
        if (oerror) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; byte is taken on the next posedge, returns at the following negedge.
    task automatic send_byte(input logic [7:0] b, input logic perr);
        i8b    = b;
        ivalid = 1'b1;
        iperr  = perr;
        @(negedge clk);
        ivalid = 1'b0;
        iperr  = 1'b0;
        i8b    = 8'h00;
    endtask

    task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code);
        exp_q.push_back({ext, brk, code});
    endtask

    task automatic read_event(input string tag);
        logic [9:0] e;
        check({tag, "_nonempty"}, oempty, 1'b0);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL %s: scoreboard has no expected event, got %0h", tag, {oext, obreak, ocode});
        end else begin
            e = exp_q.pop_front();
            check(tag, {oext, obreak, ocode}, e);
        end
        iread = 1'b1;
        @(negedge clk);
        iread = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        i8b    = 8'h00;
        ivalid = 1'b0;
        iperr  = 1'b0;
        iread  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_empty", oempty, 1'b1);
        check("rst_full", ofull, 1'b0);
        check("rst_head", {oext, obreak, ocode}, 10'h000);
        check("rst_err", oerror, 1'b0);
        check("rst_ovf", oovf, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Make / break
        send_byte(8'h1C, 1'b0);
        expect_ev(1'b0, 1'b0, 8'h1C);
        check("mk_empty_fall", oempty, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        expect_ev(1'b0, 1'b1, 8'h1C);
        read_event("mk_make");
        read_event("mk_break");
        check("mk_drained", oempty, 1'b1);
        check("mk_hold", {oext, obreak, ocode}, {2'b01, 8'h1C});

        // Extended, and silently/noisily dropped bytes
        err_base = err_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        expect_ev(1'b1, 1'b0, 8'h75);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        expect_ev(1'b1, 1'b1, 8'h75);
        send_byte(8'hAA, 1'b0);
        settle();
        check("aa_no_err", err_cnt - err_base, 0);
        send_byte(8'h00, 1'b0);
        settle();
        check("kbd00_err", err_cnt - err_base, 1);
        read_event("ext_make");
        read_event("ext_break");
        check("ext_drained", oempty, 1'b1);

        // Timeout after F0
        err_base = err_cnt;
        send_byte(8'hF0, 1'b0);
        repeat (T - 1) @(negedge clk);
        check("to_not_yet", oerror, 1'b0);
        @(negedge clk);
        check("to_pulse", oerror, 1'b1);
        settle();
        check("to_err_cnt", err_cnt - err_base, 1);
        send_byte(8'h1C, 1'b0);
        expect_ev(1'b0, 1'b0, 8'h1C);
        read_event("to_after");

        // Byte on the final cycle beats the timeout
        err_base = err_cnt;
        send_byte(8'hF0, 1'b0);
        repeat (T - 1) @(negedge clk);
        send_byte(8'h1C, 1'b0);
        expect_ev(1'b0, 1'b1, 8'h1C);
        repeat (T + 2) @(negedge clk);
        check("to_race_no_err", err_cnt - err_base, 0);
        read_event("to_race_ev");

        // Overflow
        err_base = err_cnt;
        send_byte(8'h15, 1'b0); expect_ev(1'b0, 1'b0, 8'h15);
        send_byte(8'h1D, 1'b0); expect_ev(1'b0, 1'b0, 8'h1D);
        send_byte(8'h24, 1'b0); expect_ev(1'b0, 1'b0, 8'h24);
        check("ovf_not_full3", ofull, 1'b0);
        send_byte(8'h2D, 1'b0); expect_ev(1'b0, 1'b0, 8'h2D);
        check("ovf_full4", ofull, 1'b1);
        check("ovf_clear_yet", oovf, 1'b0);
        send_byte(8'h2C, 1'b0);
        check("ovf_set", oovf, 1'b1);
        settle();
        check("ovf_err_cnt", err_cnt - err_base, 1);
        check("ovf_still_full", ofull, 1'b1);

        // Simultaneous push/pop while full
        check("pp_head", {oext, obreak, ocode}, {2'b00, exp_q[0][7:0]});
        void'(exp_q.pop_front());
        expect_ev(1'b0, 1'b0, 8'h35);
        i8b    = 8'h35;
        ivalid = 1'b1;
        iread  = 1'b1;
        @(negedge clk);
        ivalid = 1'b0;
        iread  = 1'b0;
        check("pp_full", ofull, 1'b1);
        read_event("pp_1d");
        read_event("pp_24");
        read_event("pp_2d");
        read_event("pp_35");
        check("pp_drained", oempty, 1'b1);
        check("pp_ovf_sticky", oovf, 1'b1);

        // Parity abort mid-sequence
        err_base = err_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b1);
        settle();
        check("par_err_cnt", err_cnt - err_base, 1);
        check("par_no_event", oempty, 1'b1);
        send_byte(8'h74, 1'b0);
        expect_ev(1'b0, 1'b0, 8'h74);
        read_event("par_after");

        // Reset mid-sequence with events queued
        send_byte(8'h11, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'hE0, 1'b0);
        check("mrst_pre_count", oempty, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mrst_empty", oempty, 1'b1);
        check("mrst_full", ofull, 1'b0);
        check("mrst_err", oerror, 1'b0);
        check("mrst_ovf", oovf, 1'b0);
        check("mrst_head", {oext, obreak, ocode}, 10'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h1C, 1'b0);
        expect_ev(1'b0, 1'b0, 8'h1C);
        read_event("mrst_after");
        check("mrst_drained", oempty, 1'b1);
        check("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
